// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: BranchCtr encodings,
// controller states and the redirect-type tag used for pending redirects.
package fetch_seq_pkg;

  localparam logic [2:0] BC_SEQ    = 3'd0;
  localparam logic [2:0] BC_BRANCH = 3'd1;
  localparam logic [2:0] BC_JUMP   = 3'd2;
  localparam logic [2:0] BC_HOLD   = 3'd3;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALL,
    ST_PEND,
    ST_SQUASH
  } state_e;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_BR,
    RD_JMP
  } redir_e;

endpackage

// File: rtl/fetch_seq_stats.sv
// Event counters for the fetch sequencer: issued redirects and HOLD cycles.
// Both counters wrap modulo 2^32 and clear on rst.
module fetch_seq_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic        hold_i,
  output logic [31:0] redirect_cnt_o,
  output logic [31:0] hold_cyc_cnt_o
);

  logic [31:0] redirect_cnt_q;
  logic [31:0] hold_cyc_cnt_q;

  // Count events in step with the registered outputs they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_q <= '0;
      hold_cyc_cnt_q <= '0;
    end else begin
      if (redirect_i) redirect_cnt_q <= redirect_cnt_q + 32'd1;
      if (hold_i)     hold_cyc_cnt_q <= hold_cyc_cnt_q + 32'd1;
    end
  end

  assign redirect_cnt_o = redirect_cnt_q;
  assign hold_cyc_cnt_o = hold_cyc_cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage redirect controller. Arbitrates EX branches over ID jumps,
// inserts holds for load-use and external stalls, and owns the wrong-path
// squash window after each redirect. All outputs are registered.
// Optional statistics counters are built when FETCH_SEQ_STATS_EN is defined;
// otherwise redirect_cnt and hold_cyc_cnt are tied to zero.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int BR_SQUASH  = 2,
  parameter int JMP_SQUASH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_br_req,
  input  logic [31:0] ex_br_addr,
  input  logic        id_jmp_req,
  input  logic [31:0] id_jmp_addr,
  input  logic        ld_use_hzd,
  input  logic        ext_stall,
  output logic [2:0]  BranchCtr,
  output logic [31:0] BranchAddr,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        if_id_hold,
  output logic [31:0] redirect_cnt,
  output logic [31:0] hold_cyc_cnt
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  redir_e      pend_type_q, pend_type_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [2:0]  ctr_q, ctr_d;
  logic [31:0] addr_q, addr_d;
  logic        iff_q, iff_d;
  logic        ief_q, ief_d;
  logic        ifh_q, ifh_d;

  redir_e      req_type;
  logic [31:0] req_addr;
  redir_e      issue_type;
  logic [31:0] issue_addr;

  // Incoming request arbitration: EX branch beats ID jump.
  always_comb begin
    req_type = RD_NONE;
    req_addr = id_jmp_addr;
    if (ex_br_req) begin
      req_type = RD_BR;
      req_addr = ex_br_addr;
    end else if (id_jmp_req) begin
      req_type = RD_JMP;
    end
  end

  // Next-state and next-output decision for the controller.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_type_d = pend_type_q;
    pend_addr_d = pend_addr_q;
    ctr_d       = BC_SEQ;
    addr_d      = addr_q;
    iff_d       = 1'b0;
    ief_d       = 1'b0;
    ifh_d       = 1'b0;
    issue_type  = RD_NONE;
    issue_addr  = addr_q;

    case (state_q)
      // STALL with ext_stall low behaves exactly like RUN.
      ST_RUN, ST_STALL: begin
        if (ext_stall) begin
          ctr_d = BC_HOLD;
          ifh_d = 1'b1;
          if (req_type != RD_NONE) begin
            pend_type_d = req_type;
            pend_addr_d = req_addr;
            state_d     = ST_PEND;
          end else begin
            state_d = ST_STALL;
          end
        end else begin
          state_d    = ST_RUN;
          issue_type = req_type;
          issue_addr = req_addr;
          if (req_type == RD_NONE && ld_use_hzd) begin
            ctr_d = BC_HOLD;
            ifh_d = 1'b1;
            ief_d = 1'b1;
          end
        end
      end
      // First-latched redirect is kept until the stall releases.
      ST_PEND: begin
        if (ext_stall) begin
          ctr_d = BC_HOLD;
          ifh_d = 1'b1;
        end else begin
          issue_type = pend_type_q;
          issue_addr = pend_addr_q;
        end
      end
      // Wrong-path window: requests ignored, counter frozen during stalls.
      ST_SQUASH: begin
        if (ext_stall) begin
          ctr_d = BC_HOLD;
          ifh_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (issue_type != RD_NONE) begin
      ctr_d       = (issue_type == RD_BR) ? BC_BRANCH : BC_JUMP;
      addr_d      = issue_addr;
      iff_d       = 1'b1;
      ief_d       = (issue_type == RD_BR);
      ifh_d       = 1'b0;
      cnt_d       = (issue_type == RD_BR) ? 3'(BR_SQUASH) : 3'(JMP_SQUASH);
      state_d     = ST_SQUASH;
      pend_type_d = RD_NONE;
    end
  end

  // State, pending redirect and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      pend_type_q <= RD_NONE;
      pend_addr_q <= '0;
      ctr_q       <= BC_SEQ;
      addr_q      <= '0;
      iff_q       <= 1'b0;
      ief_q       <= 1'b0;
      ifh_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_type_q <= pend_type_d;
      pend_addr_q <= pend_addr_d;
      ctr_q       <= ctr_d;
      addr_q      <= addr_d;
      iff_q       <= iff_d;
      ief_q       <= ief_d;
      ifh_q       <= ifh_d;
    end
  end

  assign BranchCtr   = ctr_q;
  assign BranchAddr  = addr_q;
  assign if_id_flush = iff_q;
  assign id_ex_flush = ief_q;
  assign if_id_hold  = ifh_q;

`ifdef FETCH_SEQ_STATS_EN
  fetch_seq_stats u_stats (
    .clk            (clk),
    .rst            (rst),
    .redirect_i     (issue_type != RD_NONE),
    .hold_i         (ctr_d == BC_HOLD),
    .redirect_cnt_o (redirect_cnt),
    .hold_cyc_cnt_o (hold_cyc_cnt)
  );
`else
  assign redirect_cnt = 32'd0;
  assign hold_cyc_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scoreboard bench for fetch_sequencer (BR_SQUASH=2, JMP_SQUASH=1).
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_br_req;
  logic [31:0] ex_br_addr;
  logic        id_jmp_req;
  logic [31:0] id_jmp_addr;
  logic        ld_use_hzd;
  logic        ext_stall;
  logic [2:0]  BranchCtr;
  logic [31:0] BranchAddr;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        if_id_hold;
  logic [31:0] redirect_cnt;
  logic [31:0] hold_cyc_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  ctr;
    logic [31:0] addr;
    logic [2:0]  fl;
    logic [31:0] rcnt;
    logic [31:0] hcnt;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] m_redir = 0;
  logic [31:0] m_hold  = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.BR_SQUASH(2), .JMP_SQUASH(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_br_req    (ex_br_req),
    .ex_br_addr   (ex_br_addr),
    .id_jmp_req   (id_jmp_req),
    .id_jmp_addr  (id_jmp_addr),
    .ld_use_hzd   (ld_use_hzd),
    .ext_stall    (ext_stall),
    .BranchCtr    (BranchCtr),
    .BranchAddr   (BranchAddr),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .if_id_hold   (if_id_hold),
    .redirect_cnt (redirect_cnt),
    .hold_cyc_cnt (hold_cyc_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, push the expected registered result, then
  // pop and compare once the edge has updated the outputs.
  task automatic step(input string tag,
                      input logic br, input logic [31:0] ba,
                      input logic jm, input logic [31:0] ja,
                      input logic lu, input logic st, input logic rs,
                      input logic [2:0] ectr, input logic [31:0] eaddr,
                      input logic eiff, input logic eief, input logic eifh);
    exp_t e;
    exp_t got;
    ex_br_req   = br;
    ex_br_addr  = ba;
    id_jmp_req  = jm;
    id_jmp_addr = ja;
    ld_use_hzd  = lu;
    ext_stall   = st;
    rst         = rs;
    if (rs) begin
      m_redir = 0;
      m_hold  = 0;
    end else begin
      if (ectr == 3'd1 || ectr == 3'd2) m_redir = m_redir + 1;
      if (ectr == 3'd3) m_hold = m_hold + 1;
    end
    e.ctr  = ectr;
    e.addr = eaddr;
    e.fl   = {eiff, eief, eifh};
`ifdef FETCH_SEQ_STATS_EN
    e.rcnt = m_redir;
    e.hcnt = m_hold;
`else
    e.rcnt = 0;
    e.hcnt = 0;
`endif
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk({tag, ".ctr"},   {29'd0, BranchCtr}, {29'd0, got.ctr});
    chk({tag, ".addr"},  BranchAddr, got.addr);
    chk({tag, ".flags"}, {29'd0, if_id_flush, id_ex_flush, if_id_hold}, {29'd0, got.fl});
    chk({tag, ".rcnt"},  redirect_cnt, got.rcnt);
    chk({tag, ".hcnt"},  hold_cyc_cnt, got.hcnt);
  endtask

  initial begin
    ex_br_req = 0; ex_br_addr = 0; id_jmp_req = 0; id_jmp_addr = 0;
    ld_use_hzd = 0; ext_stall = 0; rst = 1;
    @(negedge clk);
    //    tag         br  ba      jm  ja      lu st rs  ctr addr    iff ief ifh
    step("rst0",     0, 0,      0, 0,      0, 0, 1,  0, 0,      0, 0, 0);
    step("rst1",     0, 0,      0, 0,      0, 0, 1,  0, 0,      0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("idle",   0, 0,      0, 0,      0, 0, 0,  0, 0,      0, 0, 0);
    step("br40",     1, 'h40,   0, 0,      0, 0, 0,  1, 'h40,   1, 1, 0);
    step("sqj1",     0, 0,      1, 'h999,  0, 0, 0,  0, 'h40,   0, 0, 0);
    step("sqj2",     0, 0,      1, 'h999,  0, 0, 0,  0, 'h40,   0, 0, 0);
    step("jmp200",   0, 0,      1, 'h200,  0, 0, 0,  2, 'h200,  1, 0, 0);
    step("jsq",      0, 0,      0, 0,      0, 0, 0,  0, 'h200,  0, 0, 0);
    step("idle2",    0, 0,      0, 0,      0, 0, 0,  0, 'h200,  0, 0, 0);
    step("both",     1, 'h80,   1, 'h100,  0, 0, 0,  1, 'h80,   1, 1, 0);
    for (int i = 0; i < 3; i++)
      step("nojmp",  0, 0,      0, 0,      0, 0, 0,  0, 'h80,   0, 0, 0);
    step("lduse",    0, 0,      0, 0,      1, 0, 0,  3, 'h80,   0, 1, 1);
    step("lduse_e",  0, 0,      0, 0,      0, 0, 0,  0, 'h80,   0, 0, 0);
    step("br_lu",    1, 'hC0,   0, 0,      1, 0, 0,  1, 'hC0,   1, 1, 0);
    step("brlu_s1",  0, 0,      0, 0,      0, 0, 0,  0, 'hC0,   0, 0, 0);
    step("brlu_s2",  0, 0,      0, 0,      0, 0, 0,  0, 'hC0,   0, 0, 0);
    step("stall1",   0, 0,      0, 0,      0, 1, 0,  3, 'hC0,   0, 0, 1);
    step("stall2j",  0, 0,      1, 'h20,   0, 1, 0,  3, 'hC0,   0, 0, 1);
    step("stall3",   0, 0,      0, 0,      0, 1, 0,  3, 'hC0,   0, 0, 1);
    step("stall4b",  1, 'h55,   0, 0,      0, 1, 0,  3, 'hC0,   0, 0, 1);
    step("pend_iss", 0, 0,      0, 0,      0, 0, 0,  2, 'h20,   1, 0, 0);
    step("pend_sq",  0, 0,      0, 0,      0, 0, 0,  0, 'h20,   0, 0, 0);
    step("stl_both", 1, 'hA0,   1, 'hB0,   0, 1, 0,  3, 'h20,   0, 0, 1);
    step("pend_br",  0, 0,      0, 0,      0, 0, 0,  1, 'hA0,   1, 1, 0);
    step("pbr_s1",   0, 0,      0, 0,      0, 0, 0,  0, 'hA0,   0, 0, 0);
    step("pbr_s2",   0, 0,      0, 0,      0, 0, 0,  0, 'hA0,   0, 0, 0);
    step("br300",    1, 'h300,  0, 0,      0, 0, 0,  1, 'h300,  1, 1, 0);
    step("sq_stall", 0, 0,      0, 0,      0, 1, 0,  3, 'h300,  0, 0, 1);
    step("sq_dec",   0, 0,      0, 0,      0, 0, 0,  0, 'h300,  0, 0, 0);
    step("sq_last",  0, 0,      1, 'h44,   0, 0, 0,  0, 'h300,  0, 0, 0);
    step("jmp44",    0, 0,      1, 'h44,   0, 0, 0,  2, 'h44,   1, 0, 0);
    step("j44_sq",   0, 0,      0, 0,      0, 0, 0,  0, 'h44,   0, 0, 0);
    step("pend77",   0, 0,      1, 'h77,   0, 1, 0,  3, 'h44,   0, 0, 1);
    step("rst_pend", 0, 0,      0, 0,      0, 1, 1,  0, 0,      0, 0, 0);
    step("post_rst", 0, 0,      0, 0,      0, 0, 0,  0, 0,      0, 0, 0);
    step("post_rs2", 0, 0,      0, 0,      0, 0, 0,  0, 0,      0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Pipeline-front controller that drives the instruction-fetch stage's `BranchCtr`/`BranchAddr` inputs. It arbitrates redirect requests from EX (taken branch) and ID (jump), inserts holds for load-use and external stalls, and issues the matching IF/ID and ID/EX flush strobes. It sits between the decode/execute hazard logic and the fetch stage, and owns the wrong-path squash window after every redirect.

## Interface
Parameters:
- `BR_SQUASH`, 2: cycles after an issued EX-branch redirect during which new redirect requests are ignored (range 1–7).
- `JMP_SQUASH`, 1: cycles after an issued ID-jump redirect during which new redirect requests are ignored (range 1–7).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous active-high reset.
- `ex_br_req` in 1: taken branch resolved in EX this cycle.
- `ex_br_addr` in 32: branch target.
- `id_jmp_req` in 1: jump decoded in ID this cycle.
- `id_jmp_addr` in 32: jump target.
- `ld_use_hzd` in 1: load-use hazard detected in ID.
- `ext_stall` in 1: memory/external stall, level.
- `BranchCtr` out 3: 0 SEQ (PC+4), 1 BRANCH, 2 JUMP, 3 HOLD (fetch keeps PC and IR).
- `BranchAddr` out 32: redirect target, valid when `BranchCtr` is 1 or 2.
- `if_id_flush` out 1: clear IF/ID register.
- `id_ex_flush` out 1: clear ID/EX register (insert bubble).
- `if_id_hold` out 1: freeze IF/ID register.
- `redirect_cnt` out 32: number of issued redirects.
- `hold_cyc_cnt` out 32: number of cycles with `BranchCtr` = HOLD.

## Operation
- All outputs are registered. The decision is made from inputs sampled at edge N and is visible from N+1 for one cycle unless stated otherwise.
- States:
  - RUN: normal operation.
  - STALL: external stall, no pending redirect.
  - PEND: external stall with a latched redirect.
  - SQUASH: wrong-path window; a 3-bit down-counter runs.
- RUN priority, highest first:
  1. `ext_stall`:
     - Output HOLD plus `if_id_hold`.
     - If `ex_br_req` or `id_jmp_req` is also present, latch the winner (EX over ID) into the pending type/address registers and go to PEND.
     - Otherwise go to STALL.
  2. `ex_br_req`: output BRANCH with `ex_br_addr`, plus `if_id_flush` and `id_ex_flush`. Load counter = `BR_SQUASH`, go to SQUASH.
  3. `id_jmp_req`: output JUMP with `id_jmp_addr`, plus `if_id_flush` only. Load counter = `JMP_SQUASH`, go to SQUASH.
  4. `ld_use_hzd`: output HOLD plus `if_id_hold` and `id_ex_flush` for one cycle. Stay in RUN.
  5. Otherwise output SEQ with all strobes low.
- STALL:
  - Output HOLD plus `if_id_hold` while `ext_stall` is high.
  - A redirect request arriving here is latched, and the state moves to PEND.
  - When `ext_stall` drops, go to RUN; that cycle's inputs are evaluated by RUN rules.
- PEND:
  - Output HOLD while `ext_stall` is high.
  - Further requests are ignored; the first-latched redirect is kept.
  - When `ext_stall` drops, issue the pending redirect with the same outputs as in RUN, then go to SQUASH with that type's count.
- SQUASH:
  - `ex_br_req`, `id_jmp_req` and `ld_use_hzd` are ignored; output SEQ.
  - The counter decrements each cycle that `ext_stall` is low. At 1, go to RUN.
  - While `ext_stall` is high: output HOLD plus `if_id_hold`, and freeze the counter.
- `BranchAddr` holds its last value when not redirecting.
- `rst` clears any pending redirect and an in-progress squash.

## Timing
- Reset values:
  - `BranchCtr` = 0, `BranchAddr` = 0.
  - All strobes 0, both counters 0.
  - State RUN, pending registers cleared.
- Latency: request at edge N gives the redirect on the outputs during N+1 → N+2, exactly one cycle. The fetch stage loads the target at edge N+2.
- Squash window: the cycles immediately after the redirect output cycle, `BR_SQUASH` or `JMP_SQUASH` long, with `ext_stall` cycles excluded.
- Simultaneous `ex_br_req` and `id_jmp_req`: EX wins, and the jump is discarded as wrong-path.
- Redirect together with `ld_use_hzd`: the redirect wins, and no hold is inserted.
- Counters wrap modulo 2^32.

## Configuration
- `FETCH_SEQ_STATS_EN` defined:
  - `redirect_cnt` increments on each issued BRANCH/JUMP.
  - `hold_cyc_cnt` increments on each HOLD output cycle.
  - Both counters clear on `rst`.
- `FETCH_SEQ_STATS_EN` undefined: both ports are tied to 0 and the counters are not built.

## Structure
- Package `fetch_seq_pkg`:
  - `BranchCtr` encoding constants: SEQ = 0, BRANCH = 1, JUMP = 2, HOLD = 3.
  - State enum: RUN, STALL, PEND, SQUASH.
  - Redirect-type typedef.
- One sub-module, `fetch_seq_stats`, holding the two 32-bit counters; instantiated only under `FETCH_SEQ_STATS_EN`.

## Test plan
- Reset, then idle 3 cycles → `BranchCtr` = 0 every cycle, all strobes 0, `BranchAddr` = 0.
- `ex_br_req` = 1 with `ex_br_addr` = 0x40 at edge 5 → in cycle 6: `BranchCtr` = 1, `BranchAddr` = 0x40, `if_id_flush` = 1, `id_ex_flush` = 1. `id_jmp_req` at edges 6 and 7 is ignored; a jump at edge 8 gives `BranchCtr` = 2 in cycle 9.
- `ex_br_req` (0x80) and `id_jmp_req` (0x100) together → `BranchCtr` = 1, `BranchAddr` = 0x80; no jump is issued afterwards.
- `ld_use_hzd` for 1 cycle → one HOLD cycle with `if_id_hold` = 1 and `id_ex_flush` = 1, then SEQ.
- `ext_stall` held 4 cycles, with `id_jmp_req` (0x20) in stall cycle 2 → 4 HOLD cycles, then `BranchCtr` = 2 with 0x20 in the cycle after `ext_stall` drops.
- `rst` asserted during PEND → next cycle `BranchCtr` = 0, and the pending jump is never issued.
